fetch_unit: RTL and testbench
=============================

# fetch_unit

Fetch stage ahead of the F→D pipeline register: owns the program counter, drives the instruction-memory request, and presents `InstrF`, `PC_nowF`, `PC_plus4F` to the F→D register through a one-entry output hold buffer. Honours `StallF` from the hazard unit. Takes branch/jump redirects from Execute (`PCSrcE`). Stops fetching on a misaligned redirect target. An empty slot is presented as all-zero fields, which is the same bubble encoding the F→D register uses on flush.

## Interface
- `RESET_PC`, default `32'h0000_0000`: first fetch address after reset.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high.
- `StallF` input 1: downstream will not consume the presented instruction this cycle.
- `PCSrcE` input 1: redirect request from Execute.
- `PC_targetE` input 32: redirect address, valid when `PCSrcE=1`.
- `imem_req` output 1: fetch request this cycle.
- `imem_addr` output 32: fetch address, equal to `pc_q`.
- `imem_ready` input 1: `imem_rdata` is valid for `imem_addr` this cycle.
- `imem_rdata` input 32: instruction word.
- `InstrF` output 32: held instruction, or 0 when empty.
- `PC_nowF` output 32: address of `InstrF`, or 0 when empty.
- `PC_plus4F` output 32: `PC_nowF + 4`, or 0 when empty.
- `validF` output 1: hold buffer holds an instruction.
- `fetch_fault` output 1: misaligned redirect seen; fetching halted.

## Operation
- State: `pc_q` (next fetch address), hold buffer (`InstrF`, `PC_nowF`, `PC_plus4F`, `validF`), FSM {BOOT, RUN, FAULT}.
- Memory handshake:
  - Memory holds no outstanding state.
  - `imem_req`/`imem_addr` are sampled every cycle, and `imem_req` may drop in any cycle.
  - A fetch completes only in a cycle with `imem_req & imem_ready`.
  - `imem_ready` with `imem_req=0` is ignored.
- BOOT:
  - Entered on reset; lasts exactly one cycle after `reset` deasserts.
  - `imem_req=0`.
  - Then goes to RUN.
- RUN:
  - `imem_req = ~validF | ~StallF`, i.e. buffer empty or being consumed this edge.
  - consume = `validF & ~StallF`.
  - accept = `imem_req & imem_ready & ~PCSrcE`.
  - On accept: load buffer with {`imem_rdata`, `pc_q`, `pc_q+4`}, set `validF=1`, and set `pc_q <= pc_q+4`.
  - On consume without accept: clear the buffer. All three fields become 0 and `validF=0`.
  - Neither consume nor accept: hold the buffer and `pc_q`.
- Redirect (`PCSrcE=1` in RUN) takes priority over `StallF` and over any memory response in the same cycle:
  - Discard the response.
  - Clear the buffer to zeros and set `validF=0`.
  - If `PC_targetE[1:0]==0`: `pc_q <= PC_targetE`.
  - Otherwise: `pc_q <= PC_targetE`, go to FAULT.
- FAULT:
  - `imem_req=0`, `fetch_fault=1`.
  - Buffer empty (zeros).
  - `pc_q` holds the bad target and is visible on `imem_addr`.
  - `PCSrcE` is ignored.
  - FAULT is left only by `reset`.
- Arithmetic: `pc_q+4` is 32-bit modulo. `32'hFFFF_FFFC` wraps to `32'h0000_0000` without a flag.

## Timing
- Reset values, held while `reset=1`:
  - `pc_q=RESET_PC`, FSM=BOOT.
  - `InstrF=PC_nowF=PC_plus4F=0`, `validF=0`, `fetch_fault=0`.
- `reset` asserted mid-transaction clears all state immediately; any response in progress is lost.
- Zero-wait memory (`imem_ready` always 1), no stall: first `validF=1` appears after the second rising edge following reset release. After that, one instruction per cycle, with `PC_nowF` stepping by 4.
- N wait cycles on memory give N extra cycles of `validF=0` or of held output.
- `StallF=1` with `validF=1`:
  - Outputs stable, `imem_req=0`, `pc_q` stable.
  - On release, the held instruction is consumed on the next edge while the next fetch is accepted on that same edge.
- Redirect at edge k:
  - After edge k: `validF=0`, `InstrF=0`.
  - After edge k+1: earliest target instruction, with zero-wait memory.
- `imem_req`, `imem_addr`, `fetch_fault` are combinational from registered state plus `StallF`. Outputs to F→D come only from registers.

## Test plan
- **Reset and stream**: `RESET_PC=32'h100`, zero-wait memory, `imem_rdata = addr ^ 32'hA5A5_0000`, `StallF=0`. Required: BOOT cycle with `imem_req=0`, then `PC_nowF` = 0x100, 0x104, 0x108 on consecutive cycles, with matching `InstrF` and `PC_plus4F`.
- **Stall hold**: `StallF=1` for 3 cycles while `PC_nowF=0x104`. Required: outputs frozen, `imem_req=0`. After release, next cycle shows `PC_nowF=0x108`, with no skipped or duplicated address.
- **Wait states**: `imem_ready` low 2 cycles at addr 0x10C. Required: `validF=0` for 2 cycles after 0x108 is consumed, then `InstrF` for 0x10C.
- **Redirect with collision**: `PCSrcE=1`, `PC_targetE=32'h200`, `StallF=1`, `imem_ready=1`, all in the same cycle. Required: response dropped, `InstrF=0`, `validF=0`, then `PC_nowF=0x200`.
- **Misaligned redirect**: `PC_targetE=32'h202`. Required: `fetch_fault=1`, `imem_req=0`, `imem_addr=0x202` indefinitely. Asynchronous `reset` pulse mid-cycle restores all reset values.
- **Wrap**: `RESET_PC=32'hFFFF_FFFC`. Required: `PC_plus4F=0`, and the next `PC_nowF=0`.

Source files
------------

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues instruction-memory requests and presents
// the fetched instruction to the F->D register through a one-entry hold buffer.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        PCSrcE,
  input  logic [31:0] PC_targetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrF,
  output logic [31:0] PC_nowF,
  output logic [31:0] PC_plus4F,
  output logic        validF,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_now_q, pc_now_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        valid_q, valid_d;
  logic        consume, accept;
  logic [31:0] pc_inc;

  assign pc_inc      = pc_q + 32'd4;
  assign imem_req    = (state_q == RUN) && (!valid_q || !StallF);
  assign imem_addr   = pc_q;
  assign fetch_fault = (state_q == FAULT);
  assign consume     = valid_q && !StallF;
  assign accept      = imem_req && imem_ready && !PCSrcE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      pc_now_q   <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_now_q   <= pc_now_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc_now_d   = pc_now_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        // Redirect wins over both stall and any same-cycle memory response.
        if (PCSrcE) begin
          pc_d       = PC_targetE;
          instr_d    = '0;
          pc_now_d   = '0;
          pc_plus4_d = '0;
          valid_d    = 1'b0;
          if (PC_targetE[1:0] != 2'b00) state_d = FAULT;
        end else if (accept) begin
          instr_d    = imem_rdata;
          pc_now_d   = pc_q;
          pc_plus4_d = pc_inc;
          valid_d    = 1'b1;
          pc_d       = pc_inc;
        end else if (consume) begin
          instr_d    = '0;
          pc_now_d   = '0;
          pc_plus4_d = '0;
          valid_d    = 1'b0;
        end
      end
      FAULT: begin
        instr_d    = '0;
        pc_now_d   = '0;
        pc_plus4_d = '0;
        valid_d    = 1'b0;
      end
      default: state_d = BOOT;
    endcase
  end

  assign InstrF    = instr_q;
  assign PC_nowF   = pc_now_q;
  assign PC_plus4F = pc_plus4_q;
  assign validF    = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: one instance streaming from 0x100, one
// starting at 0xFFFF_FFFC to exercise PC wrap.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        StallF = 1'b0, PCSrcE = 1'b0, imem_ready = 1'b1;
  logic [31:0] PC_targetE = '0;
  logic        imem_req, validF, fetch_fault;
  logic [31:0] imem_addr, imem_rdata, InstrF, PC_nowF, PC_plus4F;

  logic        b_req, b_valid, b_fault;
  logic [31:0] b_addr, b_rdata, b_instr, b_pcnow, b_plus4;

  int unsigned n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ 32'hA5A5_0000;
  assign b_rdata    = b_addr ^ 32'hA5A5_0000;

  fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk(clk), .reset(reset), .StallF(StallF), .PCSrcE(PCSrcE),
    .PC_targetE(PC_targetE), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .InstrF(InstrF),
    .PC_nowF(PC_nowF), .PC_plus4F(PC_plus4F), .validF(validF),
    .fetch_fault(fetch_fault)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(reset), .StallF(1'b0), .PCSrcE(1'b0),
    .PC_targetE(32'h0), .imem_req(b_req), .imem_addr(b_addr),
    .imem_ready(1'b1), .imem_rdata(b_rdata), .InstrF(b_instr),
    .PC_nowF(b_pcnow), .PC_plus4F(b_plus4), .validF(b_valid),
    .fetch_fault(b_fault)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        stall, pcsrc, ready;
    logic [31:0] target;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr, pcnow;
    logic        fault;
  } vec_t;

  vec_t vecs[17];

  initial begin
    // {stall, pcsrc, ready, target, req, addr, valid, instr, pcnow, fault}
    vecs[0]  = '{0, 0, 1, 32'h0,   0, 32'h100, 0, 32'h0,         32'h0,   0}; // BOOT
    vecs[1]  = '{0, 0, 1, 32'h0,   1, 32'h100, 0, 32'h0,         32'h0,   0};
    vecs[2]  = '{0, 0, 1, 32'h0,   1, 32'h104, 1, 32'hA5A5_0100, 32'h100, 0};
    vecs[3]  = '{1, 0, 1, 32'h0,   0, 32'h108, 1, 32'hA5A5_0104, 32'h104, 0}; // stall x3
    vecs[4]  = '{1, 0, 1, 32'h0,   0, 32'h108, 1, 32'hA5A5_0104, 32'h104, 0};
    vecs[5]  = '{1, 0, 1, 32'h0,   0, 32'h108, 1, 32'hA5A5_0104, 32'h104, 0};
    vecs[6]  = '{0, 0, 1, 32'h0,   1, 32'h108, 1, 32'hA5A5_0104, 32'h104, 0};
    vecs[7]  = '{0, 0, 0, 32'h0,   1, 32'h10C, 1, 32'hA5A5_0108, 32'h108, 0}; // wait x2
    vecs[8]  = '{0, 0, 0, 32'h0,   1, 32'h10C, 0, 32'h0,         32'h0,   0};
    vecs[9]  = '{0, 0, 1, 32'h0,   1, 32'h10C, 0, 32'h0,         32'h0,   0};
    vecs[10] = '{0, 1, 1, 32'h180, 1, 32'h110, 1, 32'hA5A5_010C, 32'h10C, 0}; // redirect, ready
    vecs[11] = '{1, 1, 1, 32'h200, 1, 32'h180, 0, 32'h0,         32'h0,   0}; // collision
    vecs[12] = '{0, 0, 1, 32'h0,   1, 32'h200, 0, 32'h0,         32'h0,   0};
    vecs[13] = '{0, 1, 1, 32'h202, 1, 32'h204, 1, 32'hA5A5_0200, 32'h200, 0}; // misaligned
    vecs[14] = '{0, 1, 1, 32'h300, 0, 32'h202, 0, 32'h0,         32'h0,   1};
    vecs[15] = '{0, 0, 1, 32'h0,   0, 32'h202, 0, 32'h0,         32'h0,   1};
    vecs[16] = '{1, 1, 1, 32'h400, 0, 32'h202, 0, 32'h0,         32'h0,   1};

    #1 check("reset_valid", {31'd0, validF}, 32'd0);
    check("reset_req", {31'd0, imem_req}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      if (i > 0) @(negedge clk);
      StallF     = vecs[i].stall;
      PCSrcE     = vecs[i].pcsrc;
      imem_ready = vecs[i].ready;
      PC_targetE = vecs[i].target;
      #1;
      check($sformatf("v%0d_req", i),   {31'd0, imem_req},    {31'd0, vecs[i].req});
      check($sformatf("v%0d_addr", i),  imem_addr,            vecs[i].addr);
      check($sformatf("v%0d_valid", i), {31'd0, validF},      {31'd0, vecs[i].valid});
      check($sformatf("v%0d_instr", i), InstrF,               vecs[i].instr);
      check($sformatf("v%0d_pcnow", i), PC_nowF,              vecs[i].pcnow);
      check($sformatf("v%0d_plus4", i), PC_plus4F,
            vecs[i].valid ? vecs[i].pcnow + 32'd4 : 32'd0);
      check($sformatf("v%0d_fault", i), {31'd0, fetch_fault}, {31'd0, vecs[i].fault});
    end

    // Asynchronous reset pulse mid-cycle, out of FAULT.
    @(posedge clk);
    #3 reset = 1'b1;
    StallF = 1'b0; PCSrcE = 1'b0; imem_ready = 1'b1; PC_targetE = '0;
    #1;
    check("areset_fault", {31'd0, fetch_fault}, 32'd0);
    check("areset_addr", imem_addr, 32'h100);
    check("areset_req", {31'd0, imem_req}, 32'd0);
    check("areset_valid", {31'd0, validF}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("boot_req", {31'd0, imem_req}, 32'd0);
    check("wrap_boot_req", {31'd0, b_req}, 32'd0);
    check("wrap_boot_addr", b_addr, 32'hFFFF_FFFC);
    @(negedge clk); #1;
    check("run_req", {31'd0, imem_req}, 32'd1);
    check("wrap_req", {31'd0, b_req}, 32'd1);
    @(negedge clk); #1;
    check("restart_pcnow", PC_nowF, 32'h100);
    check("wrap_pcnow0", b_pcnow, 32'hFFFF_FFFC);
    check("wrap_plus4_0", b_plus4, 32'h0);
    check("wrap_instr0", b_instr, 32'h5A5A_FFFC);
    check("wrap_addr", b_addr, 32'h0);
    @(negedge clk); #1;
    check("wrap_pcnow1", b_pcnow, 32'h0);
    check("wrap_plus4_1", b_plus4, 32'h4);
    check("wrap_instr1", b_instr, 32'hA5A5_0000);
    check("wrap_fault", {31'd0, b_fault}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
